// File: rtl/mult_pkg.sv
// Shared types and constants for the truncated a*b^3 arithmetic leaf.
`timescale 1ns/1ps
package mult_pkg;

  // Operand and result width; the shift-add arrays are built for 8 bits.
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage : mult_pkg

// File: rtl/mult_trunc_8x8.sv
// Combinational truncated 8x8 shift-add multiplier: p = (x*y) mod 256.
// Each partial product is x gated by one bit of y and shifted into place;
// bits that shift past bit 7 are dropped because they never reach p.
`timescale 1ns/1ps
module mult_trunc_8x8
  import mult_pkg::*;
(
  input  data_t x,
  input  data_t y,
  output data_t p
);

  data_t w_pp [DATA_W];     // gated, shifted partial products
  data_t w_s1 [DATA_W/2];   // first adder-tree level
  data_t w_s2 [DATA_W/4];   // second adder-tree level

  // Build the gated partial products and reduce them with a balanced adder tree.
  // NOTE: every always_comb output is fully assigned on every pass; a path that
  // skips an assignment would infer a latch.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      w_pp[i] = y[i] ? data_t'(x << i) : '0;
    end
    for (int i = 0; i < DATA_W/2; i++) begin
      w_s1[i] = w_pp[2*i] + w_pp[2*i+1];
    end
    for (int i = 0; i < DATA_W/4; i++) begin
      w_s2[i] = w_s1[2*i] + w_s1[2*i+1];
    end
  end

  assign p = w_s2[0] + w_s2[1];

endmodule : mult_trunc_8x8

// File: rtl/mult_8x8.sv
// a*b^3 truncated to 8 bits: a purely combinational result plus a registered
// copy for pipelined consumers. Truncating each stage is exact modulo 256.
`timescale 1ns/1ps
module mult_8x8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] out_q
);

  import mult_pkg::data_t;

  data_t w_p1;   // (a*b)  mod 256
  data_t w_p2;   // (p1*b) mod 256
  data_t w_out;  // (p2*b) mod 256
  data_t r_out_q;

  mult_trunc_8x8 u_stage1 (.x(a),    .y(b), .p(w_p1));
  mult_trunc_8x8 u_stage2 (.x(w_p1), .y(b), .p(w_p2));
  mult_trunc_8x8 u_stage3 (.x(w_p2), .y(b), .p(w_out));

  assign out   = w_out;
  assign out_q = r_out_q;

  // Capture the combinational result each edge; reset clears it immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering. out_q is the only
  // state in this block, so it is the only thing the reset needs to clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

endmodule : mult_8x8

// File: tb/tb_mult_8x8.sv
// Scoreboard bench for mult_8x8: stimulus pushes expected values into a queue,
// a monitor pops and compares them against out or out_q on each sample strobe.
`timescale 1ns/1ps
module tb_mult_8x8;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic [7:0] out_q;

  typedef struct {
    string      name;
    bit         sel_q;   // 0: compare out, 1: compare out_q
    logic [7:0] exp;
  } chk_t;

  chk_t sb[$];
  bit   strobe;
  int   total;
  int   bad;

  mult_8x8 #(.DATA_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .out  (out),
    .out_q(out_q)
  );

  // Clock only toggles when enabled so combinational checks run clock-free.
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, exp);
    end
  endtask

  // Monitor: drain the scoreboard whenever stimulus signals a sample point.
  initial begin
    chk_t c;
    forever begin
      @(strobe);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        check(c.name, c.sel_q ? out_q : out, c.exp);
      end
    end
  end

  task automatic expect_now(input string name, input bit sel_q, input logic [7:0] exp);
    sb.push_back('{name: name, sel_q: sel_q, exp: exp});
    strobe = ~strobe;
    #1;
  endtask

  task automatic apply_comb(input string name, input logic [7:0] av,
                            input logic [7:0] bv, input logic [7:0] exp);
    a = av;
    b = bv;
    #1;
    expect_now(name, 1'b0, exp);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    int unsigned prod;

    total  = 0;
    bad    = 0;
    strobe = 1'b0;
    clk_en = 1'b0;
    rst    = 1'b0;
    a      = 8'd0;
    b      = 8'd0;

    // Asynchronous reset with no clock running.
    #1 rst = 1'b1;
    #1 expect_now("reset_async", 1'b1, 8'd0);

    // a then b in 1-unit steps, sampled one unit later.
    a = 8'd2;
    #1 b = 8'd3;
    #1 expect_now("a2_b3", 1'b0, 8'd54);

    apply_comb("a0_b200",   8'd0,   8'd200, 8'd0);
    apply_comb("a150_b0",   8'd150, 8'd0,   8'd0);
    apply_comb("a77_b1",    8'd77,  8'd1,   8'd77);
    apply_comb("a3_b5",     8'd3,   8'd5,   8'd119);
    apply_comb("a255_b255", 8'd255, 8'd255, 8'd1);
    apply_comb("a2_b128",   8'd2,   8'd128, 8'd0);
    apply_comb("a16_b2",    8'd16,  8'd2,   8'd128);
    apply_comb("a1_b255",   8'd1,   8'd255, 8'd255);
    apply_comb("a1_b7",     8'd1,   8'd7,   8'd87);   // 343 mod 256

    // Random sweep against an integer golden model.
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      prod = (32'(ra) * 32'(rb) * 32'(rb) * 32'(rb)) & 32'hFF;
      apply_comb("random", ra, rb, 8'(prod));
    end

    // Register path: held in reset while the clock starts.
    a = 8'd7;
    b = 8'd3;
    clk_en = 1'b1;
    @(posedge clk);
    #1 expect_now("held_in_reset", 1'b1, 8'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 expect_now("first_load_7_3", 1'b1, 8'd189);

    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    #1 expect_now("no_load_before_edge", 1'b1, 8'd189);
    @(posedge clk);
    #1 expect_now("load_3_5", 1'b1, 8'd119);

    @(negedge clk);
    a = 8'd255;
    b = 8'd255;
    @(posedge clk);
    #1 expect_now("load_255_255", 1'b1, 8'd1);

    // Mid-stream reset pulse, away from any clock edge.
    #1 rst = 1'b1;
    #1 expect_now("reset_midstream", 1'b1, 8'd0);
    @(posedge clk);
    #1 expect_now("reset_holds", 1'b1, 8'd0);

    @(negedge clk);
    rst = 1'b0;
    a = 8'd16;
    b = 8'd2;
    @(posedge clk);
    #1 expect_now("reload_16_2", 1'b1, 8'd128);

    clk_en = 1'b0;

    // Every pushed expectation must have been consumed by the monitor.
    for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_mult_8x8
